mac_divider: RTL and testbench



---
 rtl/mac_divider_if.sv | 25 ++
 rtl/mac_divider.sv | 140 ++++++++++++++
 tb/tb_mac_divider.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/mac_divider_if.sv
// Handshake and data bundle between a sequencing controller and mac_divider.
// The controller drives the request side (master); the divider answers (slave).
interface mac_divider_if #(
    parameter int DW = 22,
    parameter int VW = 8
);
    logic          start;
    logic [DW-1:0] dividend;
    logic [VW-1:0] divisor;
    logic          busy;
    logic          done;
    logic [DW-1:0] quotient;
    logic [VW-1:0] remainder;
    logic          dbz;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, dbz
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, dbz
    );
endinterface

// File: rtl/mac_divider.sv
// Sequential restoring divider: DW-bit accumulator value divided by a VW-bit
// unsigned divisor, one quotient bit per clock.
//
// state | meaning
// IDLE  | waiting for start; operands captured on the accepting edge
// RUN   | iterating, one quotient bit per edge, busy high
// DONE  | one-cycle done pulse, results valid; returns to IDLE
module mac_divider #(
    parameter int DW = 22,
    parameter int VW = 8
) (
    input  logic        clk,
    input  logic        rst,
    mac_divider_if.slave bus
);
    localparam int CW = $clog2(DW + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state;
    state_t        state_nxt;

    logic [DW-1:0] q_reg;
    logic [VW-1:0] d_reg;
    logic [VW:0]   r_reg;
    logic [CW-1:0] cnt;

    logic [DW-1:0] quot_reg;
    logic [VW-1:0] rem_reg;
    logic          dbz_reg;

    logic [VW+1:0] trial;
    logic          trial_neg;
    logic [VW:0]   r_nxt;
    logic [DW-1:0] q_nxt;

    logic          accept;
    logic          div_zero;
    logic          last_iter;

    // One restoring step: shift {R,Q} left, try subtracting D, restore on borrow.
    // r_reg[VW] is always 0 between steps, so {r_reg, q_msb} is the shifted R
    // already zero-extended to VW+2 bits.
    always_comb begin
        trial     = {r_reg, q_reg[DW-1]} - {2'b00, d_reg};
        trial_neg = trial[VW+1];
        r_nxt     = trial_neg ? {r_reg[VW-1:0], q_reg[DW-1]} : trial[VW:0];
        q_nxt     = {q_reg[DW-2:0], ~trial_neg};
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode and per-cycle control strobes.
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        div_zero  = 1'b0;
        last_iter = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    accept = 1'b1;
                    if (bus.divisor == '0) begin
                        div_zero  = 1'b1;
                        state_nxt = DONE;
                    end else begin
                        state_nxt = RUN;
                    end
                end
            end
            RUN: begin
                if (cnt == CW'(1)) begin
                    last_iter = 1'b1;
                    state_nxt = DONE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Working registers: load operands on accept, then iterate while in RUN.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q_reg <= '0;
            d_reg <= '0;
            r_reg <= '0;
            cnt   <= '0;
        end else if (accept && !div_zero) begin
            q_reg <= bus.dividend;
            d_reg <= bus.divisor;
            r_reg <= '0;
            cnt   <= CW'(DW);
        end else if (state == RUN) begin
            q_reg <= q_nxt;
            r_reg <= r_nxt;
            cnt   <= cnt - CW'(1);
        end
    end

    // Result registers hold until the next division completes or is rejected.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            quot_reg <= '0;
            rem_reg  <= '0;
            dbz_reg  <= 1'b0;
        end else if (accept && div_zero) begin
            quot_reg <= '1;
            rem_reg  <= '0;
            dbz_reg  <= 1'b1;
        end else if (last_iter) begin
            quot_reg <= q_nxt;
            rem_reg  <= r_nxt[VW-1:0];
            dbz_reg  <= 1'b0;
        end
    end

    // busy/done decode straight from the state register, so no input reaches
    // an output combinationally and the two can never overlap.
    assign bus.busy      = (state == RUN);
    assign bus.done      = (state == DONE);
    assign bus.quotient  = quot_reg;
    assign bus.remainder = rem_reg;
    assign bus.dbz       = dbz_reg;
endmodule

// File: tb/tb_mac_divider.sv
// Directed bench for mac_divider: hand-computed divisions, divide-by-zero,
// held-start throughput and a mid-division reset abort.
module tb_mac_divider;
    logic clk;
    logic rst;
    int   total  = 0;
    int   passed = 0;

    mac_divider_if #(.DW(22), .VW(8)) bus ();

    mac_divider #(.DW(22), .VW(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    // Start one division from IDLE and check latency, busy length and results.
    task automatic run_div(input string tag, input logic [21:0] a, input logic [7:0] b,
                           input logic [21:0] eq, input logic [7:0] er, input logic edbz);
        int busy_cyc;
        int wait_cyc;
        int overlap;
        busy_cyc = 0;
        wait_cyc = 0;
        overlap  = 0;
        @(negedge clk);
        bus.dividend = a;
        bus.divisor  = b;
        bus.start    = 1'b1;
        @(negedge clk);
        bus.start    = 1'b0;
        while (bus.done !== 1'b1 && wait_cyc < 40) begin
            if (bus.busy === 1'b1) busy_cyc++;
            @(negedge clk);
            wait_cyc++;
        end
        if (bus.busy === 1'b1 && bus.done === 1'b1) overlap++;
        check({tag, ".done"},      32'(bus.done), 32'd1);
        check({tag, ".latency"},   32'(wait_cyc), edbz ? 32'd0 : 32'd22);
        check({tag, ".busy_cyc"},  32'(busy_cyc), edbz ? 32'd0 : 32'd22);
        check({tag, ".overlap"},   32'(overlap),  32'd0);
        check({tag, ".quotient"},  32'(bus.quotient),  32'(eq));
        check({tag, ".remainder"}, 32'(bus.remainder), 32'(er));
        check({tag, ".dbz"},       32'(bus.dbz),  32'(edbz));
        @(negedge clk);
        check({tag, ".done_1cyc"}, 32'(bus.done), 32'd0);
    endtask

    initial begin
        int pulses;
        int idle_done;
        logic [21:0] hs_q [3];
        logic [7:0]  hs_r [3];
        int          hs_c [3];

        bus.start    = 1'b0;
        bus.dividend = '0;
        bus.divisor  = '0;
        rst          = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        check("reset.busy",      32'(bus.busy),      32'd0);
        check("reset.done",      32'(bus.done),      32'd0);
        check("reset.quotient",  32'(bus.quotient),  32'd0);
        check("reset.remainder", 32'(bus.remainder), 32'd0);
        check("reset.dbz",       32'(bus.dbz),       32'd0);

        run_div("basic",    22'd1000,     8'd7,   22'd142,      8'd6,  1'b0);
        run_div("fs255",    22'h3FFFFF,   8'd255, 22'd16448,    8'd63, 1'b0);
        run_div("fs1",      22'h3FFFFF,   8'd1,   22'h3FFFFF,   8'd0,  1'b0);
        run_div("small",    22'd5,        8'd200, 22'd0,        8'd5,  1'b0);
        run_div("zero_div", 22'd0,        8'd9,   22'd0,        8'd0,  1'b0);
        run_div("dbz",      22'd500,      8'd0,   22'h3FFFFF,   8'd0,  1'b1);
        run_div("after_dbz",22'd500,      8'd4,   22'd125,      8'd0,  1'b0);

        // Held start with a dividend that changes every cycle: accepts land at
        // cycles 0, 24, 48, so 1000/10, 1024/10, 1048/10 are the results.
        hs_q[0] = 22'd100; hs_r[0] = 8'd0; hs_c[0] = 23;
        hs_q[1] = 22'd102; hs_r[1] = 8'd4; hs_c[1] = 47;
        hs_q[2] = 22'd104; hs_r[2] = 8'd8; hs_c[2] = 71;
        pulses = 0;
        @(negedge clk);
        bus.divisor = 8'd10;
        for (int c = 0; c <= 72; c++) begin
            if (bus.done === 1'b1) begin
                if (pulses < 3) begin
                    check("hs.pulse_cycle", 32'(c),             32'(hs_c[pulses]));
                    check("hs.quotient",    32'(bus.quotient),  32'(hs_q[pulses]));
                    check("hs.remainder",   32'(bus.remainder), 32'(hs_r[pulses]));
                end
                pulses++;
            end
            if (c == 40) check("hs.hold_quotient", 32'(bus.quotient), 32'd100);
            if (c == 60) check("hs.hold_remainder", 32'(bus.remainder), 32'd4);
            if (c == 72) begin
                bus.start = 1'b0;
            end else begin
                bus.start    = 1'b1;
                bus.dividend = 22'(1000 + c);
            end
            @(negedge clk);
        end
        check("hs.pulses", 32'(pulses), 32'd3);

        // Reset abort ten edges into a 1000/7 division.
        bus.dividend = 22'd1000;
        bus.divisor  = 8'd7;
        bus.start    = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (9) @(negedge clk);
        check("abort.busy_before", 32'(bus.busy), 32'd1);
        @(posedge clk);
        #1 rst = 1'b0;
        #1;
        check("abort.busy",      32'(bus.busy),      32'd0);
        check("abort.done",      32'(bus.done),      32'd0);
        check("abort.quotient",  32'(bus.quotient),  32'd0);
        check("abort.remainder", 32'(bus.remainder), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        idle_done = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (bus.done === 1'b1 || bus.busy === 1'b1) idle_done++;
        end
        check("abort.no_done", 32'(idle_done), 32'd0);
        run_div("post_abort", 22'd65025, 8'd255, 22'd255, 8'd0, 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
